// File: rtl/parking_pkg.sv
// parking_pkg: gate FSM state encodings and default lot parameters shared by the gate controller and display logic
package parking_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_ENTRY_OPEN = 2'd1, ST_EXIT_OPEN = 2'd2, ST_HOLD = 2'd3;
  localparam int DEF_CAPACITY = 16;
  localparam int DEF_CNT_W = 5;
  localparam int DEF_GATE_TIMEOUT = 5000;
  localparam int DEF_GUARD_CYCLES = 100;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ENTRY_OPEN = ST_ENTRY_OPEN,
    EXIT_OPEN = ST_EXIT_OPEN,
    HOLD = ST_HOLD
  } state_t;
endpackage

// File: rtl/parking_gate_controller_if.sv
// parking_gate_controller_if: sensor/pass inputs and gate/status outputs of the parking gate controller
//   master: sensor stage and status consumer (drives sensors/pass pulses, reads gates and status)
//   slave : controller (reads sensors/pass pulses, drives gates, occupancy, full/empty, timeout, reject)
interface parking_gate_controller_if import parking_pkg::*; #(parameter int CNT_W = DEF_CNT_W);
  logic entry_sensor, exit_sensor, entry_passed, exit_passed;
  logic entry_gate_open, exit_gate_open, full, empty, gate_timeout, entry_rejected;
  logic [CNT_W-1:0] occupancy;
  modport master(
    output entry_sensor, exit_sensor, entry_passed, exit_passed,
    input entry_gate_open, exit_gate_open, occupancy, full, empty, gate_timeout, entry_rejected
  );
  modport slave(
    input entry_sensor, exit_sensor, entry_passed, exit_passed,
    output entry_gate_open, exit_gate_open, occupancy, full, empty, gate_timeout, entry_rejected
  );
endinterface

// File: rtl/parking_gate_controller_gate_timer.sv
// gate_timer: loadable down-counter; clear_i restarts the count from load_i, done_o is high while the count is zero
//   clk, rst : clock, synchronous active-high reset (count to zero)
//   clear_i  : reload the count from load_i
//   load_i   : reload value (cycles - 1 of the interval being timed)
//   done_o   : count has reached zero
module gate_timer #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic [W-1:0] load_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? load_i : cnt_q - W'(cnt_q != '0);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: entry/exit barrier FSM with saturating occupancy count, gate timeout and full-lot rejection
//   clk, reset : clock, synchronous active-high reset
//   bus (slave): sensor levels and pass pulses in; gate commands, occupancy, full/empty,
//                gate_timeout and entry_rejected pulses out, all registered
module parking_gate_controller import parking_pkg::*; #(
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input logic clk,
  input logic reset,
  parking_gate_controller_if.slave bus
);
  localparam int TW = $clog2(GATE_TIMEOUT);
  localparam int GW = GUARD_CYCLES > 1 ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  state_t state_q, state_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic full_q, empty_q, entry_gate_q, exit_gate_q, timeout_q, timeout_d, rejected_q, entry_sensor_q;
  logic open_done, guard_done;
  // Timers reload every cycle outside their state, so each starts fresh on entry (interval = load + 1 cycles)
  gate_timer #(.W(TW)) u_open (
    .clk, .rst(reset), .clear_i(state_q == IDLE), .load_i(TW'(GATE_TIMEOUT - 1)), .done_o(open_done)
  );
  gate_timer #(.W(GW)) u_guard (
    .clk, .rst(reset), .clear_i(state_q != HOLD), .load_i(GW'(GUARD_CYCLES - 1)), .done_o(guard_done)
  );
  always_comb begin
    state_d = state_q;
    occ_d = occ_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: state_d = bus.exit_sensor && !empty_q ? EXIT_OPEN : bus.entry_sensor && !full_q ? ENTRY_OPEN : IDLE;
      // A pass on the expiry cycle wins over the timeout
      ENTRY_OPEN:
        if (bus.entry_passed) begin
          occ_d = occ_q + CNT_W'(occ_q != CAP);
          state_d = HOLD;
        end else if (open_done) begin
          timeout_d = 1'b1;
          state_d = HOLD;
        end
      EXIT_OPEN:
        if (bus.exit_passed) begin
          occ_d = occ_q - CNT_W'(occ_q != '0);
          state_d = HOLD;
        end else if (open_done) begin
          timeout_d = 1'b1;
          state_d = HOLD;
        end
      HOLD: state_d = guard_done ? IDLE : HOLD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      occ_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      entry_gate_q <= 1'b0;
      exit_gate_q <= 1'b0;
      timeout_q <= 1'b0;
      rejected_q <= 1'b0;
      entry_sensor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q <= occ_d;
      full_q <= occ_d == CAP;
      empty_q <= occ_d == '0;
      entry_gate_q <= state_d == ENTRY_OPEN;
      exit_gate_q <= state_d == EXIT_OPEN;
      timeout_q <= timeout_d;
      rejected_q <= bus.entry_sensor && !entry_sensor_q && full_q;
      entry_sensor_q <= bus.entry_sensor;
    end
  end
  assign bus.entry_gate_open = entry_gate_q;
  assign bus.exit_gate_open = exit_gate_q;
  assign bus.occupancy = occ_q;
  assign bus.full = full_q;
  assign bus.empty = empty_q;
  assign bus.gate_timeout = timeout_q;
  assign bus.entry_rejected = rejected_q;
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: directed and random stimulus checked against a timing-rule model of the gate controller
module tb_parking_gate_controller;
  localparam int CAP = 2, W = 2, T = 8, G = 2;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  parking_gate_controller_if #(.CNT_W(W)) bus();
  parking_gate_controller #(.CAPACITY(CAP), .CNT_W(W), .GATE_TIMEOUT(T), .GUARD_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  int tests = 0, fails = 0;
  int cyc = 0, m_occ = 0, m_gate = 0, t_open = 0, t_hold = 0;
  bit m_hold = 0, m_to = 0, m_rej = 0, m_prev = 0;
  // Model: gate 0 none / 1 entry / 2 exit; closure and guard expiry derived from edge numbers
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_occ = 0; m_gate = 0; m_hold = 0; m_to = 0; m_rej = 0; m_prev = 0;
    end else begin
      m_rej = bus.entry_sensor && !m_prev && m_occ == CAP;
      m_prev = bus.entry_sensor;
      m_to = 0;
      if (m_gate != 0) begin
        if (m_gate == 1 ? bus.entry_passed : bus.exit_passed) begin
          m_occ = m_gate == 1 ? (m_occ < CAP ? m_occ + 1 : m_occ) : (m_occ > 0 ? m_occ - 1 : 0);
          m_gate = 0; m_hold = 1; t_hold = cyc;
        end else if (cyc - t_open == T) begin
          m_to = 1; m_gate = 0; m_hold = 1; t_hold = cyc;
        end
      end else if (m_hold) begin
        if (cyc - t_hold == G) m_hold = 0;
      end else if (bus.exit_sensor && m_occ > 0) begin
        m_gate = 2; t_open = cyc;
      end else if (bus.entry_sensor && m_occ < CAP) begin
        m_gate = 1; t_open = cyc;
      end
    end
  end
  logic [W+5:0] exp_v, got_v;
  always @(negedge clk) begin
    exp_v = {m_gate == 1, m_gate == 2, W'(m_occ), m_occ == CAP, m_occ == 0, m_to, m_rej};
    got_v = {bus.entry_gate_open, bus.exit_gate_open, bus.occupancy, bus.full, bus.empty, bus.gate_timeout, bus.entry_rejected};
    tests++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL model cyc=%0d {eg,xg,occ,full,empty,to,rej} got=%b want=%b", cyc, got_v, exp_v);
    end
  end
  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask
  task automatic do_entry();
    bus.entry_sensor = 1; @(negedge clk);
    bus.entry_sensor = 0; bus.entry_passed = 1; @(negedge clk);
    bus.entry_passed = 0; repeat (G) @(negedge clk);
  endtask
  initial begin
    int n, tos;
    bus.entry_sensor = 0; bus.exit_sensor = 0; bus.entry_passed = 0; bus.exit_passed = 0;
    repeat (2) @(negedge clk);
    chk("rst_occ", bus.occupancy, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_gates", {bus.entry_gate_open, bus.exit_gate_open}, 0);
    reset = 0;
    bus.entry_sensor = 1; @(negedge clk);
    chk("entry_open", bus.entry_gate_open, 1);
    repeat (2) @(negedge clk);
    bus.entry_sensor = 0; @(negedge clk);
    bus.entry_passed = 1; @(negedge clk);
    bus.entry_passed = 0;
    chk("entry_close", bus.entry_gate_open, 0);
    chk("entry_occ", bus.occupancy, 1);
    chk("entry_empty", bus.empty, 0);
    repeat (G) @(negedge clk);
    do_entry();
    chk("fill_occ", bus.occupancy, 2);
    chk("fill_full", bus.full, 1);
    bus.entry_sensor = 1; @(negedge clk);
    chk("reject_gate", bus.entry_gate_open, 0);
    chk("reject_pulse", bus.entry_rejected, 1);
    @(negedge clk);
    chk("reject_once", bus.entry_rejected, 0);
    bus.entry_sensor = 0;
    bus.exit_sensor = 1; @(negedge clk);
    chk("exit_open", bus.exit_gate_open, 1);
    bus.exit_sensor = 0; bus.exit_passed = 1; @(negedge clk);
    bus.exit_passed = 0;
    chk("exit_occ", bus.occupancy, 1);
    chk("exit_full", bus.full, 0);
    repeat (G) @(negedge clk);
    bus.entry_sensor = 1; @(negedge clk);
    bus.entry_sensor = 0;
    n = 0; tos = 0;
    for (int i = 0; i < 20; i++) begin
      n += int'(bus.entry_gate_open);
      tos += int'(bus.gate_timeout);
      @(negedge clk);
    end
    chk("timeout_open_cycles", n, T);
    chk("timeout_pulses", tos, 1);
    chk("timeout_occ", bus.occupancy, 1);
    bus.entry_sensor = 1; bus.exit_sensor = 1; @(negedge clk);
    chk("simul_exit", bus.exit_gate_open, 1);
    chk("simul_entry", bus.entry_gate_open, 0);
    bus.exit_sensor = 0; bus.exit_passed = 1; @(negedge clk);
    bus.exit_passed = 0;
    repeat (G + 1) @(negedge clk);
    chk("simul_entry_after", bus.entry_gate_open, 1);
    bus.entry_sensor = 0;
    bus.exit_passed = 1; @(negedge clk);
    bus.exit_passed = 0;
    repeat (T - 2) @(negedge clk);
    bus.entry_passed = 1; @(negedge clk);
    bus.entry_passed = 0;
    chk("collide_occ", bus.occupancy, 1);
    chk("collide_to", bus.gate_timeout, 0);
    repeat (G) @(negedge clk);
    bus.exit_passed = 1; @(negedge clk);
    bus.exit_passed = 0;
    chk("stray_idle_occ", bus.occupancy, 1);
    do_entry();
    bus.exit_sensor = 1; @(negedge clk);
    chk("mid_exit_open", bus.exit_gate_open, 1);
    reset = 1; @(negedge clk);
    chk("mid_rst_gate", bus.exit_gate_open, 0);
    chk("mid_rst_occ", bus.occupancy, 0);
    chk("mid_rst_empty", bus.empty, 1);
    reset = 0; bus.exit_sensor = 0;
    repeat (4000) begin
      bus.entry_sensor = ($urandom_range(0, 3) == 0) ^ bus.entry_sensor;
      bus.exit_sensor = ($urandom_range(0, 4) == 0) ^ bus.exit_sensor;
      bus.entry_passed = $urandom_range(0, 5) == 0;
      bus.exit_passed = $urandom_range(0, 5) == 0;
      reset = $urandom_range(0, 299) == 0;
      @(negedge clk);
    end
    reset = 0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/parking_gate_controller.md
# parking_gate_controller

Consumes the debounced sensor levels and one-cycle `entry_passed`/`exit_passed` pulses from the sensor interface stage. Runs the entry and exit barrier gates, and keeps the saturating occupancy count against a fixed capacity. Reports full/empty, gate timeouts and rejected entries to the display/status logic downstream.

## Interface
- `CAPACITY`, default 16: number of parking spaces; range 1 to 2^CNT_W−1.
- `CNT_W`, default 5: occupancy counter width.
- `GATE_TIMEOUT`, default 5000: maximum cycles a gate stays open without a pass pulse; must be ≥2.
- `GUARD_CYCLES`, default 100: cycles both gates are held closed after any gate closes; must be ≥1.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous reset, active-high.
- `entry_sensor` in 1: debounced vehicle-present level at the entry.
- `exit_sensor` in 1: debounced vehicle-present level at the exit.
- `entry_passed` in 1: one-cycle pulse; a vehicle has cleared the entry.
- `exit_passed` in 1: one-cycle pulse; a vehicle has cleared the exit.
- `entry_gate_open` out 1: entry barrier open command.
- `exit_gate_open` out 1: exit barrier open command.
- `occupancy` out CNT_W: vehicles currently inside.
- `full` out 1: `occupancy == CAPACITY`.
- `empty` out 1: `occupancy == 0`.
- `gate_timeout` out 1: one-cycle pulse; a gate closed on timeout.
- `entry_rejected` out 1: one-cycle pulse; an entry request was refused because the lot is full.

## Operation
- FSM states are IDLE, ENTRY_OPEN, EXIT_OPEN and HOLD.
- **IDLE**:
  - If `exit_sensor` and not `empty`, go to EXIT_OPEN. Exit has priority when both sensors are high.
  - Otherwise, if `entry_sensor` and not `full`, go to ENTRY_OPEN.
  - Otherwise stay in IDLE.
- **ENTRY_OPEN**:
  - On `entry_passed`, increment `occupancy` and go to HOLD.
  - If the open timer reaches GATE_TIMEOUT−1 with no pass, pulse `gate_timeout`, leave `occupancy` unchanged and go to HOLD.
- **EXIT_OPEN**: same as ENTRY_OPEN, using `exit_passed`, with `occupancy` decremented.
- **HOLD**: both gates closed. Return to IDLE after GUARD_CYCLES cycles.
- **Pulse on the same cycle as timeout expiry**: the pass wins; count is updated and no `gate_timeout` pulse.
- **Stray pass pulses** (received in IDLE, in HOLD, or on the opposite gate's pulse line) are ignored.
- **Occupancy limits**: the count never exceeds CAPACITY and never wraps below 0. An increment at CAPACITY or a decrement at 0 is suppressed.
- **entry_rejected**: pulses once on each rising edge of `entry_sensor` seen while `full` is high, in any state. It uses a registered copy of the previous `entry_sensor`.
- **Open timer**: CNT width is clog2(GATE_TIMEOUT). It clears on entering an open state and counts every cycle while in that state.
- **HOLD counter**: clears on entering HOLD.

## Timing
- All outputs are registered.
- **Reset values**: state IDLE, both gates 0, `occupancy` 0, `full` 0, `empty` 1, `gate_timeout` 0, `entry_rejected` 0, timers 0.
- **Reset mid-operation**: gates close and `occupancy` returns to 0 on the next edge.
- **Open latency**: sensor high at edge N (in IDLE) gives gate open from N+1.
- **Close latency**: pass pulse sampled at edge M gives gate 0 and updated `occupancy`/`full`/`empty` from M+1.
- **Timeout**: a gate opened at N with no pass closes at N+GATE_TIMEOUT, with `gate_timeout` high for that one cycle.
- **HOLD duration**: entered at edge K, state is IDLE at K+GUARD_CYCLES. The earliest reopen is K+GUARD_CYCLES+1.
- **entry_rejected latency**: high in the cycle after the sampled rising edge.
- **Gate exclusivity**: `entry_gate_open` and `exit_gate_open` are never high together.

## Structure
- Shared package/header `parking_pkg` holds:
  - state encodings (2-bit localparams: IDLE=0, ENTRY_OPEN=1, EXIT_OPEN=2, HOLD=3);
  - default CAPACITY, GATE_TIMEOUT and GUARD_CYCLES constants, also used by the display block.
- One sub-module: `gate_timer`, a loadable down-counter with a `clear` input and a `done` output. It is instantiated twice, once for the open timeout and once for the HOLD guard.
- FSM, occupancy arithmetic and edge detect live in the top level.

## Test plan
Run with CAPACITY=2, CNT_W=2, GATE_TIMEOUT=8, GUARD_CYCLES=2.
- **Basic entry**: assert `entry_sensor` for 3 cycles, then `entry_passed` 1 cycle later → `entry_gate_open` goes 1→0, `occupancy` 0→1, `empty` drops, state reaches IDLE 2 cycles after close.
- **Fill and reject**: do two entries → `occupancy`=2 and `full`=1. A third `entry_sensor` rise → gate stays closed and `entry_rejected` pulses exactly once. An exit with `exit_passed` → `occupancy`=1 and `full`=0.
- **Timeout**: open the entry gate and send no pass → gate closes exactly 8 cycles after opening, `gate_timeout` is high 1 cycle, `occupancy` unchanged.
- **Simultaneous requests**: with `occupancy`=1, raise both sensors in the same cycle → only `exit_gate_open` asserts. After its pass and HOLD, the entry gate opens.
- **Stray pulses and pass/timeout collision**: `exit_passed` in IDLE and `entry_passed` during EXIT_OPEN → no count change. A pass on the final timeout cycle → count updated and no `gate_timeout`.
- **Reset mid-operation**: assert `reset` while EXIT_OPEN with `occupancy`=2 → next edge gives all gates 0, `occupancy`=0, `empty`=1, state IDLE.
